// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg: shared FSM state type and AXI response codes for the AXI-Lite arbiter
package axil_arb_pkg;
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_RESP} arb_state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin picker
// ports: req[1:0] requests, last = most recently served index, winner = picked index, any = some request
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);
  assign any    = |req;
  assign winner = &req ? ~last : req[1];
endmodule

// File: rtl/axil_arb2.sv
// axil_arb2: two-master to one-slave AXI4-Lite arbiter, round-robin, one transaction in flight
// ports: clk/rst_n (sync, active-low); s0_axil_*/s1_axil_* master-facing AXI-Lite slaves;
//        m_axil_* toward the shared slave; grant = current/last granted master; busy = not idle
module axil_arb2
  import axil_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 128,
  parameter  int ADDR_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
  input  logic [2:0]            s0_axil_awprot,
  input  logic                  s0_axil_awvalid,
  output logic                  s0_axil_awready,
  input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
  input  logic                  s0_axil_wvalid,
  output logic                  s0_axil_wready,
  output logic [1:0]            s0_axil_bresp,
  output logic                  s0_axil_bvalid,
  input  logic                  s0_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
  input  logic [2:0]            s0_axil_arprot,
  input  logic                  s0_axil_arvalid,
  output logic                  s0_axil_arready,
  output logic [DATA_WIDTH-1:0] s0_axil_rdata,
  output logic [1:0]            s0_axil_rresp,
  output logic                  s0_axil_rvalid,
  input  logic                  s0_axil_rready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
  input  logic [2:0]            s1_axil_awprot,
  input  logic                  s1_axil_awvalid,
  output logic                  s1_axil_awready,
  input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
  input  logic                  s1_axil_wvalid,
  output logic                  s1_axil_wready,
  output logic [1:0]            s1_axil_bresp,
  output logic                  s1_axil_bvalid,
  input  logic                  s1_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
  input  logic [2:0]            s1_axil_arprot,
  input  logic                  s1_axil_arvalid,
  output logic                  s1_axil_arready,
  output logic [DATA_WIDTH-1:0] s1_axil_rdata,
  output logic [1:0]            s1_axil_rresp,
  output logic                  s1_axil_rvalid,
  input  logic                  s1_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic                  grant,
  output logic                  busy
);
  arb_state_t state_q, state_d;
  logic gnt_q, gnt_d, last_q, last_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic winner, any, win_wreq;
  logic sel_awvalid, sel_wvalid, sel_arvalid, sel_bready, sel_rready;
  logic st_wr, st_wr_resp, st_rd, st_rd_resp;
  logic aw_fwd, w_fwd;
  rr_arb2 u_rr (
    .req    ({s1_axil_awvalid | s1_axil_arvalid, s0_axil_awvalid | s0_axil_arvalid}),
    .last   (last_q),
    .winner (winner),
    .any    (any)
  );
  assign win_wreq    = winner ? s1_axil_awvalid : s0_axil_awvalid;
  assign sel_awvalid = gnt_q ? s1_axil_awvalid : s0_axil_awvalid;
  assign sel_wvalid  = gnt_q ? s1_axil_wvalid  : s0_axil_wvalid;
  assign sel_arvalid = gnt_q ? s1_axil_arvalid : s0_axil_arvalid;
  assign sel_bready  = gnt_q ? s1_axil_bready  : s0_axil_bready;
  assign sel_rready  = gnt_q ? s1_axil_rready  : s0_axil_rready;
  assign st_wr      = state_q == WR;
  assign st_wr_resp = state_q == WR_RESP;
  assign st_rd      = state_q == RD;
  assign st_rd_resp = state_q == RD_RESP;
  // a channel stays open only until its handshake, so AW/W are never replayed
  assign aw_fwd = st_wr & ~aw_done_q;
  assign w_fwd  = st_wr & ~w_done_q;
  assign m_axil_awaddr  = gnt_q ? s1_axil_awaddr : s0_axil_awaddr;
  assign m_axil_awprot  = gnt_q ? s1_axil_awprot : s0_axil_awprot;
  assign m_axil_wdata   = gnt_q ? s1_axil_wdata  : s0_axil_wdata;
  assign m_axil_wstrb   = gnt_q ? s1_axil_wstrb  : s0_axil_wstrb;
  assign m_axil_araddr  = gnt_q ? s1_axil_araddr : s0_axil_araddr;
  assign m_axil_arprot  = gnt_q ? s1_axil_arprot : s0_axil_arprot;
  assign m_axil_awvalid = aw_fwd & sel_awvalid;
  assign m_axil_wvalid  = w_fwd & sel_wvalid;
  assign m_axil_arvalid = st_rd & sel_arvalid;
  assign m_axil_bready  = st_wr_resp & sel_bready;
  assign m_axil_rready  = st_rd_resp & sel_rready;
  assign s0_axil_awready = aw_fwd & ~gnt_q & m_axil_awready;
  assign s1_axil_awready = aw_fwd &  gnt_q & m_axil_awready;
  assign s0_axil_wready  = w_fwd & ~gnt_q & m_axil_wready;
  assign s1_axil_wready  = w_fwd &  gnt_q & m_axil_wready;
  assign s0_axil_arready = st_rd & ~gnt_q & m_axil_arready;
  assign s1_axil_arready = st_rd &  gnt_q & m_axil_arready;
  assign s0_axil_bvalid  = st_wr_resp & ~gnt_q & m_axil_bvalid;
  assign s1_axil_bvalid  = st_wr_resp &  gnt_q & m_axil_bvalid;
  assign s0_axil_rvalid  = st_rd_resp & ~gnt_q & m_axil_rvalid;
  assign s1_axil_rvalid  = st_rd_resp &  gnt_q & m_axil_rvalid;
  assign s0_axil_bresp = m_axil_bresp;
  assign s1_axil_bresp = m_axil_bresp;
  assign s0_axil_rdata = m_axil_rdata;
  assign s1_axil_rdata = m_axil_rdata;
  assign s0_axil_rresp = m_axil_rresp;
  assign s1_axil_rresp = m_axil_rresp;
  assign grant = gnt_q;
  assign busy  = state_q != IDLE;
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: if (any) begin
        gnt_d     = winner;
        state_d   = win_wreq ? WR : RD;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      WR: begin
        aw_done_d = aw_done_q | (m_axil_awvalid & m_axil_awready);
        w_done_d  = w_done_q | (m_axil_wvalid & m_axil_wready);
        state_d   = aw_done_d & w_done_d ? WR_RESP : WR;
      end
      WR_RESP: if (m_axil_bvalid & m_axil_bready) begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      RD: state_d = m_axil_arvalid & m_axil_arready ? RD_RESP : RD;
      RD_RESP: if (m_axil_rvalid & m_axil_rready) begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axil_arb2.sv
// tb_axil_arb2: directed self-checking bench for axil_arb2
module tb_axil_arb2;
  import axil_arb_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] s0_awaddr = '0, s1_awaddr = '0, s0_araddr = '0, s1_araddr = '0, m_awaddr, m_araddr;
  logic [2:0] s0_awprot = '0, s1_awprot = '0, s0_arprot = '0, s1_arprot = '0, m_awprot, m_arprot;
  logic s0_awvalid = 0, s1_awvalid = 0, s0_wvalid = 0, s1_wvalid = 0, s0_arvalid = 0, s1_arvalid = 0;
  logic s0_bready = 0, s1_bready = 0, s0_rready = 0, s1_rready = 0;
  logic s0_awready, s1_awready, s0_wready, s1_wready, s0_arready, s1_arready;
  logic s0_bvalid, s1_bvalid, s0_rvalid, s1_rvalid;
  logic [127:0] s0_wdata = '0, s1_wdata = '0, s0_rdata, s1_rdata, m_wdata, m_rdata = '0, mem_word;
  logic [15:0] s0_wstrb = '0, s1_wstrb = '0, m_wstrb;
  logic [1:0] s0_bresp, s1_bresp, s0_rresp, s1_rresp, m_bresp = '0, m_rresp = '0;
  logic m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
  logic m_awready = 0, m_wready = 0, m_arready = 0, m_bvalid = 0, m_rvalid = 0;
  logic grant, busy;
  int n_chk = 0, n_fail = 0;
  localparam logic [127:0] A5 = {16{8'hA5}};
  always #5 clk = ~clk;
  axil_arb2 dut (
    .clk(clk), .rst_n(rst_n),
    .s0_axil_awaddr(s0_awaddr), .s0_axil_awprot(s0_awprot), .s0_axil_awvalid(s0_awvalid), .s0_axil_awready(s0_awready),
    .s0_axil_wdata(s0_wdata), .s0_axil_wstrb(s0_wstrb), .s0_axil_wvalid(s0_wvalid), .s0_axil_wready(s0_wready),
    .s0_axil_bresp(s0_bresp), .s0_axil_bvalid(s0_bvalid), .s0_axil_bready(s0_bready),
    .s0_axil_araddr(s0_araddr), .s0_axil_arprot(s0_arprot), .s0_axil_arvalid(s0_arvalid), .s0_axil_arready(s0_arready),
    .s0_axil_rdata(s0_rdata), .s0_axil_rresp(s0_rresp), .s0_axil_rvalid(s0_rvalid), .s0_axil_rready(s0_rready),
    .s1_axil_awaddr(s1_awaddr), .s1_axil_awprot(s1_awprot), .s1_axil_awvalid(s1_awvalid), .s1_axil_awready(s1_awready),
    .s1_axil_wdata(s1_wdata), .s1_axil_wstrb(s1_wstrb), .s1_axil_wvalid(s1_wvalid), .s1_axil_wready(s1_wready),
    .s1_axil_bresp(s1_bresp), .s1_axil_bvalid(s1_bvalid), .s1_axil_bready(s1_bready),
    .s1_axil_araddr(s1_araddr), .s1_axil_arprot(s1_arprot), .s1_axil_arvalid(s1_arvalid), .s1_axil_arready(s1_arready),
    .s1_axil_rdata(s1_rdata), .s1_axil_rresp(s1_rresp), .s1_axil_rvalid(s1_rvalid), .s1_axil_rready(s1_rready),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb), .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
    .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
    .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
    .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready),
    .grant(grant), .busy(busy)
  );
  property hold(v, r);
    @(posedge clk) disable iff (!rst_n) v && !r |=> v;
  endproperty
  a_aw0: assert property (hold(s0_awvalid, s0_awready));
  a_w0:  assert property (hold(s0_wvalid, s0_wready));
  a_ar0: assert property (hold(s0_arvalid, s0_arready));
  a_aw1: assert property (hold(s1_awvalid, s1_awready));
  a_w1:  assert property (hold(s1_wvalid, s1_wready));
  a_ar1: assert property (hold(s1_arvalid, s1_arready));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask
  task automatic rd_round(input logic w);
    tick;
    chk("tie_grant", grant, w);
    chk("tie_araddr", m_araddr, w ? 128'h200 : 128'h100);
    m_arready = 1;
    #1 chk("tie_loser_arready", w ? s0_arready : s1_arready, 0);
    tick;
    m_arready = 0;
    m_rvalid  = 1;
    m_rdata   = w ? 128'h22 : 128'h11;
    #1 chk("tie_win_rvalid", w ? s1_rvalid : s0_rvalid, 1);
    chk("tie_lose_rvalid", w ? s0_rvalid : s1_rvalid, 0);
    chk("tie_rdata", w ? s1_rdata : s0_rdata, w ? 128'h22 : 128'h11);
    tick;
    m_rvalid = 0;
    #1 chk("tie_idle", busy, 0);
  endtask
  initial begin
    do_reset;
    #1 chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_mvalid", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    // single write from master 0
    s0_awaddr = 32'h1000; s0_awvalid = 1; s0_wdata = A5; s0_wstrb = 16'hFFFF; s0_wvalid = 1;
    #1 chk("idle_awvalid", m_awvalid, 0);
    chk("idle_s0_awready", s0_awready, 0);
    tick;
    chk("wr_awvalid", m_awvalid, 1);
    chk("wr_wvalid", m_wvalid, 1);
    chk("wr_awaddr", m_awaddr, 128'h1000);
    chk("wr_wdata", m_wdata, A5);
    chk("wr_wstrb", m_wstrb, 128'hFFFF);
    chk("wr_busy", busy, 1);
    m_awready = 1; m_wready = 1;
    #1 chk("wr_s0_ready", {s0_awready, s0_wready}, 2'b11);
    chk("wr_s1_ready", {s1_awready, s1_wready}, 0);
    mem_word = m_wdata;
    tick;
    s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_wready = 0;
    m_bvalid = 1; m_bresp = RESP_OKAY; s0_bready = 1; s1_bready = 1;
    #1 chk("b_s0_bvalid", s0_bvalid, 1);
    chk("b_s1_bvalid", s1_bvalid, 0);
    chk("b_s0_bresp", s0_bresp, RESP_OKAY);
    chk("b_m_bready", m_bready, 1);
    chk("b_m_awvalid", m_awvalid, 0);
    tick;
    m_bvalid = 0;
    #1 chk("b_idle", busy, 0);
    // read back from master 0
    s0_araddr = 32'h1000; s0_arvalid = 1; s0_rready = 1;
    tick;
    chk("rd_arvalid", m_arvalid, 1);
    chk("rd_araddr", m_araddr, 128'h1000);
    m_arready = 1;
    #1 chk("rd_s0_arready", s0_arready, 1);
    tick;
    s0_arvalid = 0; m_arready = 0; m_rvalid = 1; m_rdata = mem_word; m_rresp = RESP_OKAY;
    #1 chk("rd_s0_rvalid", s0_rvalid, 1);
    chk("rd_s0_rdata", s0_rdata, A5);
    chk("rd_s1_rvalid", s1_rvalid, 0);
    chk("rd_m_rready", m_rready, 1);
    tick;
    m_rvalid = 0;
    // round-robin ties over four rounds
    do_reset;
    s0_araddr = 32'h100; s1_araddr = 32'h200; s0_arvalid = 1; s1_arvalid = 1; s1_rready = 1;
    for (int r = 0; r < 4; r++) rd_round(r[0]);
    s0_arvalid = 0; s1_arvalid = 0;
    do_reset;
    // split write from master 1
    m_awready = 1; m_wready = 1;
    s1_awaddr = 32'h2000; s1_awvalid = 1;
    tick;
    chk("sp_grant", grant, 1);
    chk("sp_awvalid", m_awvalid, 1);
    chk("sp_wvalid", m_wvalid, 0);
    chk("sp_awaddr", m_awaddr, 128'h2000);
    tick;
    s1_awvalid = 0;
    #1 chk("sp_busy1", busy, 1);
    chk("sp_no_aw", m_awvalid, 0);
    tick;
    chk("sp_busy2", busy, 1);
    s1_wvalid = 1; s1_wdata = 128'h1234; s1_wstrb = 16'h000F;
    #1 chk("sp_wvalid_late", m_wvalid, 1);
    chk("sp_s1_wready", s1_wready, 1);
    chk("sp_wdata", m_wdata, 128'h1234);
    chk("sp_aw_again", m_awvalid, 0);
    tick;
    s1_wvalid = 0; m_bvalid = 1; m_bresp = RESP_SLVERR;
    #1 chk("sp_s1_bvalid", s1_bvalid, 1);
    chk("sp_s1_bresp", s1_bresp, RESP_SLVERR);
    chk("sp_s0_bvalid", s0_bvalid, 0);
    tick;
    m_bvalid = 0;
    #1 chk("sp_idle", busy, 0);
    // write beats read for the same master
    s0_awaddr = 32'h3000; s0_awvalid = 1; s0_wvalid = 1; s0_araddr = 32'h3000; s0_arvalid = 1;
    tick;
    chk("pr_awvalid", m_awvalid, 1);
    chk("pr_arvalid", m_arvalid, 0);
    chk("pr_grant", grant, 0);
    tick;
    s0_awvalid = 0; s0_wvalid = 0; m_bvalid = 1; m_bresp = RESP_OKAY;
    #1 chk("pr_bvalid", s0_bvalid, 1);
    chk("pr_arready", s0_arready, 0);
    tick;
    m_bvalid = 0;
    #1 chk("pr_idle", busy, 0);
    tick;
    chk("pr_rd_arvalid", m_arvalid, 1);
    chk("pr_rd_grant", grant, 0);
    m_arready = 1;
    tick;
    s0_arvalid = 0; m_arready = 0;
    // read data backpressure with master 1 waiting
    s0_rready = 0; m_rvalid = 1; m_rdata = 128'hDEAD_BEEF; s1_araddr = 32'h200; s1_arvalid = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_rdata", s0_rdata, 128'hDEAD_BEEF);
      chk("bp_rvalid", s0_rvalid, 1);
      chk("bp_m_rready", m_rready, 0);
      chk("bp_s1_arready", s1_arready, 0);
      tick;
    end
    s0_rready = 1;
    #1 chk("bp_release", m_rready, 1);
    tick;
    m_rvalid = 0;
    tick;
    chk("bp_next_grant", grant, 1);
    chk("bp_next_arvalid", m_arvalid, 1);
    m_arready = 1;
    tick;
    s1_arvalid = 0; m_arready = 0; m_rvalid = 1; s1_rready = 0;
    #1 chk("rs_busy_before", busy, 1);
    chk("rs_s1_rvalid_before", s1_rvalid, 1);
    // reset during RD_RESP
    rst_n = 0;
    tick;
    rst_n = 1; m_rvalid = 0;
    #1 chk("rs_busy", busy, 0);
    chk("rs_grant", grant, 0);
    chk("rs_valids", {s0_rvalid, s1_rvalid, m_awvalid, m_wvalid, m_arvalid}, 0);
    s0_araddr = 32'h100; s0_arvalid = 1; s1_arvalid = 1;
    tick;
    chk("rs_tie_grant", grant, 0);
    chk("rs_tie_araddr", m_araddr, 128'h100);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_arb2.md
# axil_arb2

Two-master to one-slave AXI4-Lite arbiter placed between the `a25_top` core port (master 0) and `axil_ram` (slave). Master 1 is a second requester such as a boot loader, DMA or debug port. It grants the shared memory port to one master per transaction using round-robin, then forwards that master's channels until the transaction completes. Exactly one transaction (read or write) is in flight at a time.

## Interface
- DATA_WIDTH, 128, AXI-Lite data width, all ports
- ADDR_WIDTH, 32, AXI-Lite address width
- STRB_WIDTH, DATA_WIDTH/8, write strobe width (derived, not overridable)
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- sN_axil_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1  master N (N=0,1) write address; awready out 1
- sN_axil_wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1  master N write data; wready out 1
- sN_axil_bresp/bvalid  out  2/1  master N write response; bready in 1
- sN_axil_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1  master N read address; arready out 1
- sN_axil_rdata/rresp/rvalid  out  DATA_WIDTH/2/1  master N read data; rready in 1
- m_axil_aw*/w*/ar* outputs, m_axil_awready/wready/arready inputs  same widths  toward slave
- m_axil_b*/r* inputs, m_axil_bready/rready outputs  same widths  from slave
- grant  out  1  index of the currently or last granted master
- busy  out  1  a transaction is in flight (state ≠ IDLE)

## Operation
- State machine states: IDLE, WR, WR_RESP, RD, RD_RESP. Registered grant index `gnt`, round-robin pointer `last`, flags `aw_done` and `w_done`.
- Master N request: wreq_N = awvalid_N; rreq_N = arvalid_N; req_N = wreq_N | rreq_N.
- Arbitration happens in IDLE only.
  - If one master requests, it wins.
  - If both request, the master ≠ `last` wins.
  - Winner's write takes precedence over its own read.
  - On the decision: `gnt` ← winner. State → WR if wreq, else RD. Clear `aw_done`/`w_done`.
- WR state:
  - Forward s[gnt] aw to m while !aw_done, and w while !w_done.
  - m ready is routed back to s[gnt] ready.
  - Set `aw_done` on the m AW handshake and `w_done` on the m W handshake.
  - When both are done (including same-cycle completion), go to WR_RESP.
- WR_RESP: route m b* to s[gnt]; route s[gnt] bready to m. On the B handshake: `last` ← gnt, go to IDLE.
- RD: forward s[gnt] ar to m. On the AR handshake, go to RD_RESP.
- RD_RESP: route r* and rready. On the R handshake: `last` ← gnt, go to IDLE.
- Non-granted master, and both masters in IDLE: awready/wready/arready = 0, bvalid/rvalid = 0.
- m valid outputs are 0 in IDLE and in the response states. m bready/rready are 0 outside their response state.
- Payload outputs (addr, data, strb, prot, resp) are muxed by `gnt` at all times. They are don't-care when the matching valid is 0.
- Responses are passed through unmodified; the arbiter generates no error responses.

## Timing
- Reset (rst_n = 0 at posedge): state = IDLE, gnt = 0, last = 1 (master 0 wins the first tie), aw_done = w_done = 0. Hence busy = 0, grant = 0, and all valid/ready outputs are 0.
- Arbitration latency: master valid sampled in IDLE at edge k → m valid asserted in cycle k+1.
- Forwarding is combinational in the data states, so there is zero added latency per channel.
- Back-to-back turnaround: completion handshake at edge j → IDLE in cycle j+1 → next grant visible from cycle j+2. That gives a minimum of 1 idle cycle between transactions.
- Reset asserted mid-transaction returns to IDLE on that edge. Any pending slave response is dropped; the system resets the slave in the same cycle.
- A master that drops valid before its handshake violates AXI. Behaviour in that case is undefined, and the bench asserts it never happens.

## Structure
- Package `axil_arb_pkg`:
  - `arb_state_t` enum with the 5 states.
  - AXI response constants (OKAY = 2'b00, SLVERR = 2'b10).
- One sub-module, `rr_arb2`: 2-input round-robin picker (`req[1:0]`, `last` → `winner`, `any`). It is combinational, and its `last` update is driven by the FSM.
- The FSM, flags and channel muxes live in `axil_arb2`.

## Test plan
- Single write, m0: awaddr = 0x1000, wdata = 128'hA5…A5, wstrb = 16'hFFFF, AW and W in the same cycle → m AW and W valid 1 cycle later, bresp OKAY delivered to s0 only. Then read of 0x1000 returns A5…A5.
- Tie: m0 and m1 both assert arvalid in the first cycle after reset → m0 granted first, m1 second. On the next simultaneous tie, m1 wins (alternation over 4 rounds: 0, 1, 0, 1).
- Split write, m1: AW at cycle 0, W at cycle 3 → state stays WR until W completes. AW is not re-presented to the slave after `aw_done`. busy = 1 throughout.
- Write priority: m0 asserts awvalid and arvalid together → write is performed first, then the read on m0's next arbitration win.
- Backpressure: slave holds rvalid with s0 rready = 0 for 5 cycles → rdata stable on s0, m rready = 0, and m1 requests stay blocked (arready = 0).
- Reset mid-transaction: rst_n low during RD_RESP → next cycle busy = 0, grant = 0, all valids 0. After reset, m0 wins the first tie.
